// File: rtl/defog_frame_ctrl.sv
// Frame-level controller for the dehaze pipeline: vsync-framed config commit, atmospheric-light latch,
// frame geometry measurement and line-length format check. Optional macro: DEFOG_AL_SMOOTH_EN (IIR atm light).
module defog_frame_ctrl #(
    parameter int         CNT_W     = 12,
    parameter logic [7:0] THRE_INIT = 8'd26,
    parameter int         AL_SHIFT  = 3
) (
    input  logic             pixelclk,
    input  logic             reset_p,
    input  logic             i_hsync,
    input  logic             i_vsync,
    input  logic             i_de,
    input  logic [7:0]       i_dark_max,
    input  logic [7:0]       cfg_thre,
    input  logic             cfg_bypass,
    input  logic             cfg_wr,
    output logic [7:0]       o_thre,
    output logic             o_bypass,
    output logic [7:0]       o_atm_light,
    output logic             o_frame_start,
    output logic [15:0]      o_frame_cnt,
    output logic [CNT_W-1:0] o_width,
    output logic [CNT_W-1:0] o_height,
    output logic             o_fmt_err,
    output logic             o_cfg_pending
);

    typedef enum logic [1:0] {
        S_WAIT_VS = 2'd0,
        S_VSYNC   = 2'd1,
        S_ACTIVE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state;
    logic             vs_d;
    logic             line_open;
    logic             ref_valid;
    logic             err;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] line_cnt;
    logic [CNT_W-1:0] ref_w;
    logic [7:0]       sh_thre;
    logic             sh_bypass;

    logic             b_evt;
    logic             commit;
    logic             rise;
    logic             fall;
    logic             close;
    logic [CNT_W-1:0] line_nxt;
    logic [CNT_W-1:0] pix_nxt;
    logic [CNT_W-1:0] ref_nxt;
    logic             ref_valid_nxt;
    logic             err_nxt;
    logic             open_nxt;
    logic [7:0]       atm_nxt;

    // hsync carries no information for counting; kept only as a port
    logic unused_sink;
    assign unused_sink = i_hsync ^ (AL_SHIFT > 32'sd0);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

`ifdef DEFOG_AL_SMOOTH_EN
    localparam int AW = 8 + AL_SHIFT;
    logic          al_loaded;
    logic [AW-1:0] atm_ext;
    logic [AW-1:0] dm_ext;
    logic [AW-1:0] al_sum;

    // IIR: atm*(2^K-1) + new, scaled back by 2^K; first commit loads the sample directly
    always_comb begin
        atm_ext = {{AL_SHIFT{1'b0}}, o_atm_light};
        dm_ext  = {{AL_SHIFT{1'b0}}, i_dark_max};
        al_sum  = (atm_ext << AL_SHIFT) - atm_ext + dm_ext;
        if (al_loaded) begin
            atm_nxt = al_sum[AW-1:AL_SHIFT];
        end else begin
            atm_nxt = i_dark_max;
        end
    end
`else
    // Atmospheric light follows the per-frame sample directly
    always_comb begin
        atm_nxt = i_dark_max;
    end
`endif

    // Next-state of the line/pixel counters; a line still open at the boundary closes in that cycle
    always_comb begin
        b_evt  = i_vsync & ~vs_d;
        commit = b_evt & (state == S_ACTIVE);
        rise   = i_de & ~line_open;
        fall   = ~i_de & line_open;

        if (rise) begin
            line_nxt = sat_inc(line_cnt);
            pix_nxt  = CNT_ONE;
            open_nxt = 1'b1;
        end else if (line_open && i_de) begin
            line_nxt = line_cnt;
            pix_nxt  = sat_inc(pix_cnt);
            open_nxt = 1'b1;
        end else begin
            line_nxt = line_cnt;
            pix_nxt  = pix_cnt;
            open_nxt = 1'b0;
        end

        close         = fall | (b_evt & (line_open | rise));
        ref_nxt       = ref_w;
        ref_valid_nxt = ref_valid;
        err_nxt       = err;
        if (close && !ref_valid) begin
            ref_nxt       = pix_nxt;
            ref_valid_nxt = 1'b1;
        end else if (close && (pix_nxt != ref_w)) begin
            err_nxt = 1'b1;
        end else begin
            err_nxt = err;
        end
    end

    // Frame FSM, measurement registers, config shadow/commit and all registered outputs
    always_ff @(posedge pixelclk) begin
        if (reset_p) begin
            state         <= S_WAIT_VS;
            vs_d          <= 1'b0;
            line_open     <= 1'b0;
            ref_valid     <= 1'b0;
            err           <= 1'b0;
            pix_cnt       <= CNT_ZERO;
            line_cnt      <= CNT_ZERO;
            ref_w         <= CNT_ZERO;
            sh_thre       <= THRE_INIT;
            sh_bypass     <= 1'b0;
            o_thre        <= THRE_INIT;
            o_bypass      <= 1'b0;
            o_atm_light   <= 8'd0;
            o_frame_start <= 1'b0;
            o_frame_cnt   <= 16'd0;
            o_width       <= CNT_ZERO;
            o_height      <= CNT_ZERO;
            o_fmt_err     <= 1'b0;
            o_cfg_pending <= 1'b0;
`ifdef DEFOG_AL_SMOOTH_EN
            al_loaded     <= 1'b0;
`endif
        end else begin
            vs_d          <= i_vsync;
            o_frame_start <= 1'b0;

            if (cfg_wr) begin
                sh_thre   <= cfg_thre;
                sh_bypass <= cfg_bypass;
            end else begin
                sh_thre   <= sh_thre;
                sh_bypass <= sh_bypass;
            end

            case (state)
                S_WAIT_VS: begin
                    if (b_evt) begin
                        state <= S_VSYNC;
                    end else begin
                        state <= S_WAIT_VS;
                    end
                end
                S_VSYNC: begin
                    line_open <= 1'b0;
                    ref_valid <= 1'b0;
                    err       <= 1'b0;
                    pix_cnt   <= CNT_ZERO;
                    line_cnt  <= CNT_ZERO;
                    ref_w     <= CNT_ZERO;
                    if (!i_vsync) begin
                        state <= S_ACTIVE;
                    end else begin
                        state <= S_VSYNC;
                    end
                end
                S_ACTIVE: begin
                    line_open <= open_nxt;
                    ref_valid <= ref_valid_nxt;
                    err       <= err_nxt;
                    pix_cnt   <= pix_nxt;
                    line_cnt  <= line_nxt;
                    ref_w     <= ref_nxt;
                    if (b_evt) begin
                        state         <= S_VSYNC;
                        o_width       <= ref_nxt;
                        o_height      <= line_nxt;
                        o_fmt_err     <= err_nxt;
                        o_frame_cnt   <= o_frame_cnt + 16'd1;
                        o_frame_start <= 1'b1;
                        o_atm_light   <= atm_nxt;
`ifdef DEFOG_AL_SMOOTH_EN
                        al_loaded     <= 1'b1;
`endif
                    end else begin
                        state <= S_ACTIVE;
                    end
                end
                default: begin
                    state <= S_WAIT_VS;
                end
            endcase

            // A write landing on the commit cycle takes effect at that same commit
            if (commit) begin
                o_cfg_pending <= 1'b0;
                if (cfg_wr) begin
                    o_thre   <= cfg_thre;
                    o_bypass <= cfg_bypass;
                end else if (o_cfg_pending) begin
                    o_thre   <= sh_thre;
                    o_bypass <= sh_bypass;
                end else begin
                    o_thre   <= o_thre;
                    o_bypass <= o_bypass;
                end
            end else if (cfg_wr) begin
                o_cfg_pending <= 1'b1;
            end else begin
                o_cfg_pending <= o_cfg_pending;
            end
        end
    end

endmodule

// File: tb/tb_defog_frame_ctrl.sv
// Self-checking bench for defog_frame_ctrl: frame-level reference model built from line-length lists.
module tb_defog_frame_ctrl;

    logic        clk = 1'b0;
    logic        reset_p;
    logic        i_hsync, i_vsync, i_de;
    logic [7:0]  i_dark_max, cfg_thre;
    logic        cfg_bypass, cfg_wr;
    logic [7:0]  o_thre, o_atm_light;
    logic        o_bypass, o_frame_start, o_fmt_err, o_cfg_pending;
    logic [15:0] o_frame_cnt;
    logic [11:0] o_width, o_height;

    always #5 clk = ~clk;

    defog_frame_ctrl dut (
        .pixelclk(clk), .reset_p(reset_p), .i_hsync(i_hsync), .i_vsync(i_vsync), .i_de(i_de),
        .i_dark_max(i_dark_max), .cfg_thre(cfg_thre), .cfg_bypass(cfg_bypass), .cfg_wr(cfg_wr),
        .o_thre(o_thre), .o_bypass(o_bypass), .o_atm_light(o_atm_light), .o_frame_start(o_frame_start),
        .o_frame_cnt(o_frame_cnt), .o_width(o_width), .o_height(o_height), .o_fmt_err(o_fmt_err),
        .o_cfg_pending(o_cfg_pending)
    );

    assign i_hsync = ~i_de;

    int checks = 0;
    int fails  = 0;

    // reference model state
    bit          m_armed, m_loaded;
    logic [15:0] m_cnt;
    logic [11:0] m_w, m_h;
    logic        m_err, m_byp, m_sh_byp, m_pend;
    logic [7:0]  m_atm, m_thre, m_sh_thre;
    int          cur_lens[$];
    int          commits_total = 0;
    bit          last_commit;

    // pulse-width monitor
    int fs_count = 0, pw_viol = 0;
    bit prev_fs = 0;
    always @(negedge clk) begin
        if (o_frame_start) begin
            fs_count++;
            if (prev_fs) pw_viol++;
        end
        prev_fs = o_frame_start;
    end

    wire [59:0] obs = {o_frame_start, o_frame_cnt, o_width, o_height, o_fmt_err,
                       o_atm_light, o_thre, o_bypass, o_cfg_pending};

    function automatic logic [59:0] exp_vec(input logic fs);
        return {fs, m_cnt, m_w, m_h, m_err, m_atm, m_thre, m_byp, m_pend};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_armed = 0; m_loaded = 0; m_cnt = 16'd0; m_w = 12'd0; m_h = 12'd0; m_err = 1'b0;
        m_atm = 8'd0; m_thre = 8'd26; m_byp = 1'b0; m_sh_thre = 8'd26; m_sh_byp = 1'b0; m_pend = 1'b0;
        cur_lens.delete();
    endtask

    task automatic do_reset(input int n);
        reset_p = 1'b1; i_vsync = 1'b0; i_de = 1'b0; cfg_wr = 1'b0;
        cfg_thre = 8'd0; cfg_bypass = 1'b0; i_dark_max = 8'd0;
        repeat (n) tick();
        reset_p = 1'b0;
        model_reset();
    endtask

    task automatic add_line(input int len);
        i_de = 1'b1;
        repeat (len) tick();
        i_de = 1'b0;
        repeat (3) tick();
        if (m_armed) cur_lens.push_back(len);
    endtask

    task automatic add_frame(input int nlines, input int width, input int bad_idx, input int bad_len);
        for (int i = 0; i < nlines; i++) add_line((i == bad_idx) ? bad_len : width);
    endtask

    task automatic cfg_write(input logic [7:0] t, input logic b);
        cfg_thre = t; cfg_bypass = b; cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
        m_sh_thre = t; m_sh_byp = b; m_pend = 1'b1;
    endtask

    // Raises vsync for one cycle (the boundary) and updates the model; vsync stays high afterwards
    task automatic boundary(input logic [7:0] dark, input bit wr, input logic [7:0] t, input logic b);
        int first;
        i_dark_max = dark; i_vsync = 1'b1; cfg_wr = wr; cfg_thre = t; cfg_bypass = b;
        tick();
        cfg_wr = 1'b0;
        last_commit = m_armed;
        if (wr) begin m_sh_thre = t; m_sh_byp = b; end
        if (m_armed) begin
            first = (cur_lens.size() > 0) ? cur_lens[0] : 0;
            m_w = 12'(first);
            m_h = 12'(cur_lens.size());
            m_err = 1'b0;
            foreach (cur_lens[k]) if (cur_lens[k] != first) m_err = 1'b1;
            m_cnt = m_cnt + 16'd1;
`ifdef DEFOG_AL_SMOOTH_EN
            m_atm = m_loaded ? 8'((int'(m_atm) * 7 + int'(dark)) / 8) : dark;
`else
            m_atm = dark;
`endif
            m_loaded = 1;
            if (m_pend || wr) begin m_thre = m_sh_thre; m_byp = m_sh_byp; end
            m_pend = 1'b0;
            commits_total++;
        end else begin
            m_armed = 1;
            if (wr) m_pend = 1'b1;
        end
        cur_lens.delete();
    endtask

    task automatic end_vsync(input int hold, input int blank);
        repeat (hold) tick();
        i_vsync = 1'b0;
        repeat (blank) tick();
    endtask

    task automatic test_reset();
        do_reset(3);
        checks++;
        if (obs !== exp_vec(1'b0)) begin
            fails++; $display("FAIL reset_state obs=%h exp=%h", obs, exp_vec(1'b0));
        end
        checks++;
        if (o_thre !== 8'd26) begin
            fails++; $display("FAIL reset_thre got=%0d want=26", o_thre);
        end
    endtask

    task automatic test_geometry();
        boundary(8'd200, 1'b0, 8'd0, 1'b0);
        checks++;
        if (obs !== exp_vec(1'b0) || last_commit) begin
            fails++; $display("FAIL geom_arm obs=%h exp=%h", obs, exp_vec(1'b0));
        end
        end_vsync(2, 2);
        for (int f = 0; f < 2; f++) begin
            add_frame(8, 16, -1, 0);
            boundary(8'd200, 1'b0, 8'd0, 1'b0);
            checks++;
            if (obs !== exp_vec(1'b1)) begin
                fails++; $display("FAIL geom_frame%0d obs=%h exp=%h", f, obs, exp_vec(1'b1));
            end
            end_vsync(2, 2);
        end
        checks++;
        if (o_width !== 12'd16 || o_height !== 12'd8 || o_frame_cnt !== 16'd2 || o_fmt_err !== 1'b0) begin
            fails++; $display("FAIL geom_final w=%0d h=%0d cnt=%0d err=%0d want 16/8/2/0",
                              o_width, o_height, o_frame_cnt, o_fmt_err);
        end
    endtask

    task automatic test_config();
        add_frame(3, 16, -1, 0);
        cfg_write(8'd40, 1'b1);
        checks++;
        if (obs !== exp_vec(1'b0) || o_thre !== 8'd26 || o_cfg_pending !== 1'b1) begin
            fails++; $display("FAIL cfg_pending obs=%h exp=%h", obs, exp_vec(1'b0));
        end
        add_frame(5, 16, -1, 0);
        boundary(8'd90, 1'b0, 8'd0, 1'b0);
        checks++;
        if (obs !== exp_vec(1'b1) || o_thre !== 8'd40 || o_bypass !== 1'b1) begin
            fails++; $display("FAIL cfg_applied obs=%h exp=%h", obs, exp_vec(1'b1));
        end
        end_vsync(2, 2);
        add_frame(4, 10, -1, 0);
        cfg_write(8'd11, 1'b1);
        add_line(10);
        cfg_write(8'd77, 1'b0);
        boundary(8'd91, 1'b0, 8'd0, 1'b0);
        checks++;
        if (obs !== exp_vec(1'b1) || o_thre !== 8'd77) begin
            fails++; $display("FAIL cfg_last_wins obs=%h exp=%h", obs, exp_vec(1'b1));
        end
        end_vsync(2, 2);
        add_frame(4, 10, -1, 0);
        boundary(8'd92, 1'b1, 8'd55, 1'b1);
        checks++;
        if (obs !== exp_vec(1'b1) || o_thre !== 8'd55 || o_cfg_pending !== 1'b0) begin
            fails++; $display("FAIL cfg_on_boundary obs=%h exp=%h", obs, exp_vec(1'b1));
        end
        end_vsync(2, 2);
    endtask

    task automatic test_fmt();
        add_frame(8, 16, 4, 15);
        boundary(8'd100, 1'b0, 8'd0, 1'b0);
        checks++;
        if (obs !== exp_vec(1'b1) || o_fmt_err !== 1'b1) begin
            fails++; $display("FAIL fmt_err_set obs=%h exp=%h", obs, exp_vec(1'b1));
        end
        end_vsync(2, 2);
        add_frame(8, 16, -1, 0);
        boundary(8'd100, 1'b0, 8'd0, 1'b0);
        checks++;
        if (obs !== exp_vec(1'b1) || o_fmt_err !== 1'b0) begin
            fails++; $display("FAIL fmt_err_clear obs=%h exp=%h", obs, exp_vec(1'b1));
        end
        end_vsync(2, 2);
        boundary(8'd7, 1'b0, 8'd0, 1'b0);
        checks++;
        if (obs !== exp_vec(1'b1) || o_width !== 12'd0 || o_height !== 12'd0) begin
            fails++; $display("FAIL zero_lines obs=%h exp=%h", obs, exp_vec(1'b1));
        end
        end_vsync(2, 2);
    endtask

    task automatic test_atm();
        add_frame(2, 8, -1, 0);
        boundary(8'd200, 1'b0, 8'd0, 1'b0);
        end_vsync(2, 2);
        add_frame(2, 8, -1, 0);
        boundary(8'd120, 1'b0, 8'd0, 1'b0);
        checks++;
        if (obs !== exp_vec(1'b1)) begin
            fails++; $display("FAIL atm_light obs=%h exp=%h", obs, exp_vec(1'b1));
        end
        end_vsync(2, 2);
    endtask

    task automatic test_reset_mid();
        add_frame(4, 16, -1, 0);
        i_de = 1'b1;
        tick();
        do_reset(3);
        checks++;
        if (obs !== exp_vec(1'b0)) begin
            fails++; $display("FAIL midreset_state obs=%h exp=%h", obs, exp_vec(1'b0));
        end
        add_frame(2, 5, -1, 0);
        boundary(8'd33, 1'b0, 8'd0, 1'b0);
        checks++;
        if (obs !== exp_vec(1'b0) || o_frame_cnt !== 16'd0) begin
            fails++; $display("FAIL midreset_arm obs=%h exp=%h", obs, exp_vec(1'b0));
        end
        end_vsync(2, 2);
        add_frame(8, 16, -1, 0);
        boundary(8'd44, 1'b0, 8'd0, 1'b0);
        checks++;
        if (obs !== exp_vec(1'b1) || o_frame_cnt !== 16'd1 || o_width !== 12'd16) begin
            fails++; $display("FAIL midreset_commit obs=%h exp=%h", obs, exp_vec(1'b1));
        end
        end_vsync(2, 2);
    endtask

    task automatic test_random();
        for (int f = 0; f < 10; f++) begin
            int nl, w, bi, bl, mode;
            nl = $urandom_range(0, 9);
            w  = $urandom_range(1, 20);
            bi = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 9) : -1;
            bl = $urandom_range(1, 19);
            if (bl >= w) bl++;
            mode = $urandom_range(0, 2);
            add_frame(nl, w, bi, bl);
            if (mode == 1) cfg_write(8'($urandom), 1'($urandom));
            boundary(8'($urandom), mode == 2, 8'($urandom), 1'($urandom));
            checks++;
            if (obs !== exp_vec(1'b1)) begin
                fails++; $display("FAIL random_frame%0d obs=%h exp=%h", f, obs, exp_vec(1'b1));
            end
            end_vsync(1 + $urandom_range(0, 2), 1 + $urandom_range(0, 2));
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 4; f++) begin
            add_frame(2, 3, -1, 0);
            boundary(8'(f * 17), 1'b0, 8'd0, 1'b0);
            checks++;
            if (obs !== exp_vec(1'b1)) begin
                fails++; $display("FAIL b2b_frame%0d obs=%h exp=%h", f, obs, exp_vec(1'b1));
            end
            end_vsync(0, 1);
        end
        tick();
        checks++;
        if (pw_viol !== 0 || fs_count !== commits_total) begin
            fails++; $display("FAIL pulse_width viol=%0d pulses=%0d want 0/%0d", pw_viol, fs_count, commits_total);
        end
    endtask

    initial begin
        test_reset();
        test_geometry();
        test_config();
        test_fmt();
        test_atm();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end

endmodule
